// File: rtl/uart_cfg_arb.sv
// Round-robin arbiter that lets several requesters share the single
// configuration port of a UART transmit controller. Each granted transaction
// raises cfg_req for a fixed number of cycles, waits for the controller to go
// busy and then idle again, and reports completion or timeout to the winner.
module uart_cfg_arb #(
  parameter int NUM_REQ  = 4,
  parameter int REQ_HOLD = 4,
  parameter int GAP_CYC  = 4,
  parameter int BUSY_TO  = 256,
  parameter int DONE_TO  = 1 << 20,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_vld,
  input  logic [8*NUM_REQ-1:0]   req_addr,
  input  logic [16*NUM_REQ-1:0]  req_value,
  output logic [NUM_REQ-1:0]     req_ack,
  output logic [NUM_REQ-1:0]     req_err,
  output logic [7:0]             cfg_addr,
  output logic [15:0]            cfg_value,
  output logic                   cfg_req,
  input  logic                   cfg_done,
  output logic                   busy,
  output logic [ID_W-1:0]        grant_id
);

  localparam int HOLD_W = $clog2(REQ_HOLD + 1);
  localparam int GAP_W  = $clog2(GAP_CYC + 1);

  localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(NUM_REQ - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(REQ_HOLD - 1);
  localparam logic [GAP_W-1:0]  GAP_MAX   = GAP_W'(GAP_CYC);
  localparam logic [23:0]       BUSY_LAST = 24'(BUSY_TO - 1);
  localparam logic [23:0]       DONE_LAST = 24'(DONE_TO - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_ACK,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic [7:0]        cfg_addr_q, cfg_addr_d;
  logic [15:0]       cfg_value_q, cfg_value_d;
  logic              cfg_req_q, cfg_req_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic              seen_busy_q, seen_busy_d;
  logic [23:0]       to_cnt_q, to_cnt_d;

  logic [7:0]        addr_arr  [NUM_REQ];
  logic [15:0]       value_arr [NUM_REQ];
  logic              pick_found;
  logic [ID_W-1:0]   pick_id;
  logic [ID_W-1:0]   cand;
  logic              grant;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[8*g +: 8];
    assign value_arr[g] = req_value[16*g +: 16];
  end

  // Round-robin search starting just after the last winner, wrapping at NUM_REQ-1.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = grant_id_q;
    cand       = grant_id_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (cand == LAST_ID) ? '0 : cand + 1'b1;
      if (!pick_found && req_vld[cand]) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
    end
  end

  assign grant = (state_q == S_IDLE) && pick_found && cfg_done && (gap_cnt_q >= GAP_MAX);

  // Transaction sequencing: grant, hold cfg_req, wait busy, wait idle, report.
  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    cfg_addr_d  = cfg_addr_q;
    cfg_value_d = cfg_value_q;
    hold_cnt_d  = hold_cnt_q;
    seen_busy_d = seen_busy_q | ((state_q != S_IDLE) & ~cfg_done);
    unique case (state_q)
      S_IDLE: begin
        if (grant) begin
          state_d     = S_REQ;
          grant_id_d  = pick_id;
          cfg_addr_d  = addr_arr[pick_id];
          cfg_value_d = value_arr[pick_id];
          hold_cnt_d  = '0;
          seen_busy_d = 1'b0;
        end
      end
      S_REQ: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d = (seen_busy_q || !cfg_done) ? S_WAIT_DONE : S_WAIT_BUSY;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      S_WAIT_BUSY: begin
        if (!cfg_done) begin
          state_d = S_WAIT_DONE;
        end else if (to_cnt_q >= BUSY_LAST) begin
          state_d = S_ERR;
        end
      end
      S_WAIT_DONE: begin
        if (cfg_done) begin
          state_d = S_ACK;
        end else if (to_cnt_q >= DONE_LAST) begin
          state_d = S_ERR;
        end
      end
      S_ACK:   state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request strobe, inter-transaction gap and saturating timeout bookkeeping.
  // The timeout counter runs from grant through S_WAIT_BUSY and restarts on
  // entry to S_WAIT_DONE, so each timeout measures its own interval.
  always_comb begin
    cfg_req_d = (state_d == S_REQ);
    if (cfg_req_q) begin
      gap_cnt_d = '0;
    end else if (gap_cnt_q >= GAP_MAX) begin
      gap_cnt_d = GAP_MAX;
    end else begin
      gap_cnt_d = gap_cnt_q + 1'b1;
    end
    if ((state_q == S_IDLE) || ((state_d == S_WAIT_DONE) && (state_q != S_WAIT_DONE))) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != '1) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end else begin
      to_cnt_d = to_cnt_q;
    end
  end

  // Completion pulses go to the requester that owns the current transaction.
  always_comb begin
    req_ack = '0;
    req_err = '0;
    if (state_q == S_ACK) req_ack[grant_id_q] = 1'b1;
    if (state_q == S_ERR) req_err[grant_id_q] = 1'b1;
  end

  // State registers; grant_id resets to the last index so requester 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      grant_id_q  <= LAST_ID;
      cfg_addr_q  <= '0;
      cfg_value_q <= '0;
      cfg_req_q   <= 1'b0;
      hold_cnt_q  <= '0;
      gap_cnt_q   <= GAP_MAX;
      seen_busy_q <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      cfg_addr_q  <= cfg_addr_d;
      cfg_value_q <= cfg_value_d;
      cfg_req_q   <= cfg_req_d;
      hold_cnt_q  <= hold_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      seen_busy_q <= seen_busy_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  assign cfg_addr  = cfg_addr_q;
  assign cfg_value = cfg_value_q;
  assign cfg_req   = cfg_req_q;
  assign busy      = (state_q != S_IDLE);
  assign grant_id  = grant_id_q;

endmodule

// File: tb/tb_uart_cfg_arb.sv
// Self-checking bench for uart_cfg_arb: a scoreboard of expected grants and
// completions, plus a small behavioural model of the UART transmit controller.
module tb_uart_cfg_arb;

  localparam int NUM_REQ  = 4;
  localparam int REQ_HOLD = 4;
  localparam int GAP_CYC  = 4;
  localparam int BUSY_TO  = 16;
  localparam int DONE_TO  = 64;

  localparam int KIND_ACK  = 0;
  localparam int KIND_ERR  = 1;
  localparam int KIND_NONE = 2;

  typedef struct {
    int          id;
    logic [7:0]  addr;
    logic [15:0] value;
    int          kind;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [3:0]  req_vld;
  logic [31:0] req_addr;
  logic [63:0] req_value;
  logic [3:0]  req_ack;
  logic [3:0]  req_err;
  logic [7:0]  cfg_addr;
  logic [15:0] cfg_value;
  logic        cfg_req;
  logic        cfg_done;
  logic        busy;
  logic [1:0]  grant_id;

  logic [7:0]  addr_tab  [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
  logic [15:0] value_tab [4] = '{16'hBEEF, 16'h1234, 16'hA5A5, 16'h0F0F};

  exp_t exp_q[$];
  exp_t cur_exp;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   rise_cnt = 0;
  int   done_cnt = 0;
  int   push_cnt = 0;
  int   rise_cyc = -1000;
  int   fall_cyc = -1;
  int   resp_cyc = 0;
  int   done_rise_cyc = 0;
  int   low_len = 20;
  int   cur_low_len = 20;
  logic stuck_high = 1'b0;
  logic pending = 1'b0;

  uart_cfg_arb #(
    .NUM_REQ (NUM_REQ),
    .REQ_HOLD(REQ_HOLD),
    .GAP_CYC (GAP_CYC),
    .BUSY_TO (BUSY_TO),
    .DONE_TO (DONE_TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_vld  (req_vld),
    .req_addr (req_addr),
    .req_value(req_value),
    .req_ack  (req_ack),
    .req_err  (req_err),
    .cfg_addr (cfg_addr),
    .cfg_value(cfg_value),
    .cfg_req  (cfg_req),
    .cfg_done (cfg_done),
    .busy     (busy),
    .grant_id (grant_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s got=0x%0h want=0x%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] vld);
    req_vld = vld;
  endtask

  task automatic pushExpected(input int id, input int kind);
    exp_t e;
    e.id    = id;
    e.addr  = addr_tab[id];
    e.value = value_tab[id];
    e.kind  = kind;
    exp_q.push_back(e);
    push_cnt++;
  endtask

  task automatic waitDone(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      tick();
      n++;
    end
    checkOutput("resp_wait", 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic waitRise(input int target, input int budget);
    int n = 0;
    while (rise_cnt < target && n < budget) begin
      tick();
      n++;
    end
    checkOutput("grant_wait", 32'(rise_cnt >= target), 32'd1);
  endtask

  // Output monitor, scoreboard compare and UART controller model, all on the
  // falling edge so sampling never races the DUT's rising-edge updates.
  initial begin : monitor
    logic       prev_req;
    logic [3:0] oh;
    int         d;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) pending = 1'b0;
      if (cfg_req && !prev_req) begin
        rise_cnt++;
        rise_cyc    = cyc;
        cur_low_len = stuck_high ? 0 : low_len;
        checkOutput("grant_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          cur_exp = exp_q.pop_front();
          pending = 1'b1;
          checkOutput("grant_id", 32'(grant_id), 32'(cur_exp.id));
          checkOutput("cfg_addr", 32'(cfg_addr), 32'(cur_exp.addr));
          checkOutput("cfg_value", 32'(cfg_value), 32'(cur_exp.value));
          checkOutput("busy_on_grant", 32'(busy), 32'd1);
        end
        if (fall_cyc >= 0) checkOutput("req_gap", 32'((cyc - fall_cyc) >= GAP_CYC), 32'd1);
      end
      if (!cfg_req && prev_req) begin
        fall_cyc = cyc;
        checkOutput("req_hold", 32'(cyc - rise_cyc), 32'(REQ_HOLD));
      end
      if (req_ack != 4'b0 || req_err != 4'b0) begin
        if (pending) begin
          oh = 4'b0001 << cur_exp.id;
          checkOutput("ack_vec", 32'(req_ack), (cur_exp.kind == KIND_ACK) ? 32'(oh) : 32'd0);
          checkOutput("err_vec", 32'(req_err), (cur_exp.kind == KIND_ERR) ? 32'(oh) : 32'd0);
          checkOutput("addr_stable", 32'(cfg_addr), 32'(cur_exp.addr));
          checkOutput("value_stable", 32'(cfg_value), 32'(cur_exp.value));
          pending  = 1'b0;
          resp_cyc = cyc;
          done_cnt++;
        end else begin
          checkOutput("spurious_resp", 32'({req_ack, req_err}), 32'd0);
        end
      end
      prev_req = cfg_req;
      d = cyc - rise_cyc;
      if (stuck_high) begin
        cfg_done = 1'b1;
      end else begin
        cfg_done = !(d >= 2 && d < 2 + cur_low_len);
        if (cur_low_len > 0 && d == 2 + cur_low_len) done_rise_cyc = cyc;
      end
    end
  end

  initial begin : stimulus
    int base;
    int stim_cyc;
    rst       = 1'b1;
    cfg_done  = 1'b1;
    req_vld   = 4'b0;
    req_addr  = '0;
    req_value = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_addr[8*i +: 8]    = addr_tab[i];
      req_value[16*i +: 16] = value_tab[i];
    end
    repeat (3) tick();

    $display("[TB] reset state");
    checkOutput("rst_cfg_req", 32'(cfg_req), 32'd0);
    checkOutput("rst_cfg_addr", 32'(cfg_addr), 32'd0);
    checkOutput("rst_cfg_value", 32'(cfg_value), 32'd0);
    checkOutput("rst_ack", 32'(req_ack), 32'd0);
    checkOutput("rst_err", 32'(req_err), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_grant_id", 32'(grant_id), 32'd3);
    rst = 1'b0;
    repeat (2) tick();

    $display("[TB] all requesters");
    base = done_cnt;
    applyStimulus(4'b1111);
    pushExpected(0, KIND_ACK);
    pushExpected(1, KIND_ACK);
    pushExpected(2, KIND_ACK);
    pushExpected(3, KIND_ACK);
    pushExpected(0, KIND_ACK);
    waitDone(base + 4, 600);
    applyStimulus(4'b0001);
    waitDone(base + 5, 200);
    applyStimulus(4'b0000);
    repeat (10) tick();

    $display("[TB] single request");
    base = done_cnt;
    stim_cyc = cyc;
    applyStimulus(4'b0001);
    pushExpected(0, KIND_ACK);
    waitDone(base + 1, 200);
    applyStimulus(4'b0000);
    checkOutput("grant_latency", 32'(rise_cyc - stim_cyc), 32'd1);
    checkOutput("ack_after_done", 32'(resp_cyc - done_rise_cyc), 32'd1);
    repeat (10) tick();

    $display("[TB] busy timeout");
    stuck_high = 1'b1;
    base = done_cnt;
    applyStimulus(4'b1000);
    pushExpected(3, KIND_ERR);
    waitDone(base + 1, 200);
    applyStimulus(4'b0000);
    checkOutput("busy_to_time", 32'(resp_cyc - rise_cyc), 32'(BUSY_TO));
    tick();
    checkOutput("busy_after_err", 32'(busy), 32'd0);
    stuck_high = 1'b0;
    repeat (10) tick();

    $display("[TB] done timeout");
    low_len = 120;
    base = done_cnt;
    applyStimulus(4'b0100);
    pushExpected(2, KIND_ERR);
    waitDone(base + 1, 300);
    applyStimulus(4'b0000);
    checkOutput("done_to_time", 32'(resp_cyc - rise_cyc), 32'(REQ_HOLD + DONE_TO));
    low_len = 20;
    repeat (60) tick();

    $display("[TB] withdraw and persist");
    base = done_cnt;
    applyStimulus(4'b0010);
    pushExpected(1, KIND_ACK);
    waitRise(push_cnt, 100);
    applyStimulus(4'b0000);
    repeat (5) tick();
    applyStimulus(4'b0100);
    tick();
    applyStimulus(4'b0000);
    waitDone(base + 1, 200);
    repeat (40) tick();
    checkOutput("withdraw_grants", 32'(rise_cnt), 32'(push_cnt));

    $display("[TB] reset mid-transaction");
    applyStimulus(4'b0100);
    pushExpected(2, KIND_NONE);
    waitRise(push_cnt, 100);
    repeat (6) tick();
    rst = 1'b1;
    #1;
    checkOutput("midrst_cfg_req", 32'(cfg_req), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_grant_id", 32'(grant_id), 32'd3);
    checkOutput("midrst_cfg_addr", 32'(cfg_addr), 32'd0);
    applyStimulus(4'b0000);
    repeat (2) tick();
    rst = 1'b0;
    base = done_cnt;
    applyStimulus(4'b1111);
    pushExpected(0, KIND_ACK);
    pushExpected(1, KIND_ACK);
    pushExpected(2, KIND_ACK);
    pushExpected(3, KIND_ACK);
    waitDone(base + 4, 600);
    applyStimulus(4'b0000);
    repeat (20) tick();
    checkOutput("final_grants", 32'(rise_cnt), 32'(push_cnt));
    checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
